// File: rtl/scale_snap_arbiter.sv
// Shares one snap-to-scale lookup between NREQ pitch requesters and owns the active scale register.
// Latency: grant to rsp_valid is 4+k cycles on the normal path and 1 cycle on the error path.
// Backpressure: one request at a time; while rsp_valid is held without rsp_ready, no new grant is issued.
// The optional WAIT_DONE timeout is enabled by defining SNAP_TIMEOUT_EN.
module scale_snap_arbiter #(
    parameter int NREQ    = 2,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_note,
    input  logic [3*NREQ-1:0] req_octave,
    input  logic [NREQ-1:0]   req_greater,
    input  logic              cfg_we,
    input  logic [11:0]       cfg_scale,
    output logic [11:0]       scale_out,
    output logic [3:0]        lut_note,
    output logic [2:0]        lut_octave,
    output logic              lut_greater,
    output logic              lut_start,
    input  logic              lut_done,
    input  logic [31:0]       lut_freq,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_freq,
    output logic              rsp_err
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_RESP      = 2'd3;

    localparam logic [11:0] SCALE_C_MAJOR = 12'hAB5;

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [11:0]    scale_pend;
    logic           scale_pend_vld;

    // Arbitration results for the current cycle.
    logic           any_vld;
    logic [IDW-1:0] gnt_idx;
    logic [3:0]     gnt_note;
    logic [2:0]     gnt_octave;
    logic           gnt_greater;
    logic [11:0]    scale_eff;
    logic           gnt_bad;
    logic [IDW-1:0] ptr_next;

`ifdef SNAP_TIMEOUT_EN
    localparam int TOW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [TOW-1:0] to_cnt;
`else
    // The limit only has meaning when the timeout counter is built.
    localparam int unused_timeout = TIMEOUT;
`endif

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        any_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_vld && req_valid[idx]) begin
                any_vld = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    // Operand select for the granted requester and the scale it will be checked against.
    // A pending scale write takes effect in IDLE ahead of this cycle's arbitration.
    always_comb begin
        gnt_note    = req_note[int'(gnt_idx)*4 +: 4];
        gnt_octave  = req_octave[int'(gnt_idx)*3 +: 3];
        gnt_greater = req_greater[gnt_idx];
        scale_eff   = scale_pend_vld ? scale_pend : scale_out;
        gnt_bad     = (gnt_note > 4'd11) || (scale_eff == 12'd0);
        ptr_next    = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
    end

    // One-hot grant, only while idle and only for the arbitration winner.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == S_IDLE) && any_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Pending scale register; applied to scale_out only while idle so an in-flight lookup never sees a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_out      <= SCALE_C_MAJOR;
            scale_pend     <= 12'd0;
            scale_pend_vld <= 1'b0;
        end else if (state == S_IDLE) begin
            scale_out      <= scale_eff;
            scale_pend_vld <= cfg_we;
            if (cfg_we) begin
                scale_pend <= cfg_scale;
            end
        end else if (cfg_we) begin
            scale_pend     <= cfg_scale;
            scale_pend_vld <= 1'b1;
        end
    end

    // Request sequencer: grant, start pulse, wait for the lookup, then hold the response until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            lut_start   <= 1'b0;
            lut_note    <= 4'd0;
            lut_octave  <= 3'd0;
            lut_greater <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_freq    <= 32'd0;
            rsp_err     <= 1'b0;
`ifdef SNAP_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_vld) begin
                        lut_note    <= gnt_note;
                        lut_octave  <= gnt_octave;
                        lut_greater <= gnt_greater;
                        rsp_id      <= gnt_idx;
                        if (gnt_bad) begin
                            // Bad note or empty scale: answer immediately, never start the lookup.
                            rsp_err   <= 1'b1;
                            rsp_freq  <= 32'd0;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            lut_start <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    lut_start <= 1'b0;
                    state     <= S_WAIT_DONE;
`ifdef SNAP_TIMEOUT_EN
                    to_cnt    <= '0;
`endif
                end
                S_WAIT_DONE: begin
                    if (lut_done) begin
                        rsp_freq  <= lut_freq;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
`ifdef SNAP_TIMEOUT_EN
                    end else if (to_cnt == TOW'(TIMEOUT - 1)) begin
                        rsp_freq  <= 32'd0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= ptr_next;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scale_snap_arbiter.sv
// Directed bench for scale_snap_arbiter with a small behavioural model of the snap lookup.
// Latency of the model is k neighbour steps, set per test; lut_done can be forced low.
// Responses are accepted under bench control of rsp_ready.
module tb_scale_snap_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_note;
    logic [3*NREQ-1:0] req_octave;
    logic [NREQ-1:0]   req_greater;
    logic              cfg_we;
    logic [11:0]       cfg_scale;
    logic [11:0]       scale_out;
    logic [3:0]        lut_note;
    logic [2:0]        lut_octave;
    logic              lut_greater;
    logic              lut_start;
    logic              lut_done;
    logic [31:0]       lut_freq;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_freq;
    logic              rsp_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scale_snap_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_note(req_note), .req_octave(req_octave), .req_greater(req_greater),
        .cfg_we(cfg_we), .cfg_scale(cfg_scale), .scale_out(scale_out),
        .lut_note(lut_note), .lut_octave(lut_octave), .lut_greater(lut_greater),
        .lut_start(lut_start), .lut_done(lut_done), .lut_freq(lut_freq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_freq(rsp_freq), .rsp_err(rsp_err)
    );

    // Lookup model: done drops on start, rises k cycles later; hold_done forces it low.
    logic done_r    = 1'b0;
    int   lk_cnt    = 0;
    int   lut_k     = 0;
    logic hold_done = 1'b0;
    always @(posedge clk) begin
        if (lut_start) begin
            done_r <= 1'b0;
            lk_cnt <= lut_k;
        end else if (!done_r) begin
            if (lk_cnt == 0) done_r <= 1'b1;
            else             lk_cnt <= lk_cnt - 1;
        end
    end
    assign lut_done = done_r & ~hold_done;

    // Known reference points, otherwise a recognisable signature of the operands.
    always_comb begin
        if (lut_note == 4'd1 && lut_octave == 3'd4)      lut_freq = 32'h125AA2E3;
        else if (lut_note == 4'd9 && lut_octave == 3'd6) lut_freq = 32'h6E000000;
        else lut_freq = {16'hF00D, 4'h0, lut_note, 5'h0, lut_octave};
    end

    // Event monitor: grant order/times, response order, pulse counts.
    int cyc = 0;
    int start_cnt = 0;
    int rdy_cnt = 0;
    int gq[$];
    int gt[$];
    int rq[$];
    always @(posedge clk) begin
        if (rst_n && |req_ready) begin
            gq.push_back(req_ready[1] ? 1 : 0);
            gt.push_back(cyc);
            rdy_cnt++;
        end
        if (lut_start) start_cnt++;
        if (rsp_valid && rsp_ready) rq.push_back(int'(rsp_id));
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        chk("rsp_valid_arrives", {63'd0, rsp_valid}, 64'd1);
    endtask

    initial begin
        int n;
        int s0;
        int r0;
        logic [31:0] held_freq;

        rst_n = 1'b0; req_valid = '0; req_note = '0; req_octave = '0; req_greater = '0;
        cfg_we = 1'b0; cfg_scale = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scale", scale_out, 64'hAB5);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_lut_start", lut_start, 0);
        chk("rst_rsp_freq", rsp_freq, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_lut_ops", {lut_note, lut_octave, lut_greater}, 0);
        rst_n = 1'b1;
        tick();

        // Normal lookup, D4, k=1: rsp_valid at G+5.
        s0 = start_cnt; r0 = rdy_cnt; lut_k = 1;
        req_valid = 2'b01; req_note[3:0] = 4'd1; req_octave[2:0] = 3'd4; req_greater[0] = 1'b1;
        #1;
        chk("t1_grant", req_ready, 2'b01);
        tick();
        req_valid = '0;
        chk("t1_start", lut_start, 1);
        chk("t1_ops", {lut_note, lut_octave, lut_greater}, {4'd1, 3'd4, 1'b1});
        chk("t1_ready_low", req_ready, 0);
        tick();
        chk("t1_start_single", lut_start, 0);
        wait_rsp(n);
        chk("t1_latency", n, 3);
        chk("t1_id", rsp_id, 0);
        chk("t1_freq", rsp_freq, 32'h125AA2E3);
        chk("t1_err", rsp_err, 0);
        chk("t1_starts", start_cnt - s0, 1);
        chk("t1_readies", rdy_cnt - r0, 1);
        rsp_ready = 1'b1;
        tick();
        chk("t1_released", rsp_valid, 0);

        // Bad note on requester 1: immediate error, no lookup start.
        s0 = start_cnt;
        req_valid = 2'b10; req_note[7:4] = 4'd12; req_octave[5:3] = 3'd4; req_greater[1] = 1'b0;
        #1;
        chk("t3_grant", req_ready, 2'b10);
        tick();
        req_valid = '0;
        chk("t3_valid", rsp_valid, 1);
        chk("t3_err", rsp_err, 1);
        chk("t3_freq", rsp_freq, 0);
        chk("t3_id", rsp_id, 1);
        tick();
        chk("t3_no_start", start_cnt - s0, 0);

        // Both requesters held valid: alternate 0,1,0,1 at one grant per 5 cycles (k=0).
        lut_k = 0;
        gq.delete(); gt.delete(); rq.delete();
        req_note = {4'd2, 4'd4}; req_octave = {3'd3, 3'd3};
        req_valid = 2'b11;
        n = 0;
        while (gq.size() < 4 && n < 100) begin tick(); n++; end
        req_valid = '0;
        n = 0;
        while (rq.size() < 4 && n < 100) begin tick(); n++; end
        chk("t2_grant_count", gq.size(), 4);
        chk("t2_rsp_count", rq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_grant%0d", i), gq[i], i % 2);
            chk($sformatf("t2_rspid%0d", i), rq[i], i % 2);
        end
        chk("t2_gap", gt[1] - gt[0], 5);
        chk("t2_gap2", gt[3] - gt[2], 5);
        tick();

        // Scale write during WAIT_DONE and a long stall on rsp_ready.
        rsp_ready = 1'b0; lut_k = 3;
        req_valid = 2'b01; req_note[3:0] = 4'd1; req_octave[2:0] = 3'd4; req_greater[0] = 1'b0;
        #1;
        chk("t5_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b10; req_note[7:4] = 4'd2; req_octave[5:3] = 3'd4;
        tick();
        cfg_we = 1'b1; cfg_scale = 12'h001;
        tick();
        cfg_we = 1'b0;
        chk("t5_scale_hold", scale_out, 12'hAB5);
        wait_rsp(n);
        r0 = rdy_cnt;
        held_freq = rsp_freq;
        chk("t5_freq", rsp_freq, 32'h125AA2E3);
        for (int i = 0; i < 10; i++) begin
            chk("t5_stall_valid", rsp_valid, 1);
            chk("t5_stall_freq", rsp_freq, held_freq);
            chk("t5_stall_scale", scale_out, 12'hAB5);
            chk("t5_stall_ready", req_ready, 0);
            tick();
        end
        chk("t5_no_grant", rdy_cnt - r0, 0);
        rsp_ready = 1'b1;
        tick();
        chk("t5_next_grant", req_ready, 2'b10);
        chk("t5_scale_still", scale_out, 12'hAB5);
        tick();
        req_valid = '0;
        chk("t5_scale_new", scale_out, 12'h001);
        wait_rsp(n);
        chk("t5_id1", rsp_id, 1);
        chk("t5_freq1", rsp_freq, 32'hF00D0204);
        tick();

        // Empty scale: error with no start; then full scale and A6.
        s0 = start_cnt; lut_k = 0;
        cfg_we = 1'b1; cfg_scale = 12'h000;
        tick();
        cfg_we = 1'b0;
        tick();
        chk("t4_scale_zero", scale_out, 0);
        req_valid = 2'b01; req_note[3:0] = 4'd1; req_octave[2:0] = 3'd4;
        #1;
        chk("t4_grant", req_ready, 2'b01);
        tick();
        req_valid = '0;
        chk("t4_err_valid", rsp_valid, 1);
        chk("t4_err", rsp_err, 1);
        chk("t4_err_freq", rsp_freq, 0);
        tick();
        chk("t4_no_start", start_cnt - s0, 0);
        cfg_we = 1'b1; cfg_scale = 12'hFFF;
        tick();
        cfg_we = 1'b0;
        req_valid = 2'b01; req_note[3:0] = 4'd9; req_octave[2:0] = 3'd6;
        #1;
        chk("t4_grant2", req_ready, 2'b01);
        tick();
        req_valid = '0;
        chk("t4_scale_full", scale_out, 12'hFFF);
        wait_rsp(n);
        chk("t4_freq", rsp_freq, 32'h6E000000);
        chk("t4_ok", rsp_err, 0);
        tick();

        // Lookup never finishes.
        hold_done = 1'b1; lut_k = 0;
        req_valid = 2'b01; req_note[3:0] = 4'd1; req_octave[2:0] = 3'd4;
        tick();
        req_valid = '0;
`ifdef SNAP_TIMEOUT_EN
        wait_rsp(n);
        chk("t6_timeout_cycles", n, 17);
        chk("t6_err", rsp_err, 1);
        chk("t6_freq", rsp_freq, 0);
        tick();
        hold_done = 1'b0;
`else
        repeat (40) tick();
        chk("t6_still_waiting", rsp_valid, 0);
        hold_done = 1'b0;
        wait_rsp(n);
        chk("t6_late_err", rsp_err, 0);
        chk("t6_late_freq", rsp_freq, 32'h125AA2E3);
        tick();
`endif

        // Reset in the middle of a lookup, then recover.
        rsp_ready = 1'b0;
        req_valid = 2'b01; req_note[3:0] = 4'd2; req_octave[2:0] = 3'd5;
        tick();
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t7_rsp_valid", rsp_valid, 0);
        chk("t7_lut_ops", {lut_note, lut_octave, lut_greater}, 0);
        chk("t7_scale", scale_out, 12'hAB5);
        chk("t7_start", lut_start, 0);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();
        s0 = start_cnt;
        req_valid = 2'b01; req_note[3:0] = 4'd9; req_octave[2:0] = 3'd6;
        #1;
        chk("t7_grant", req_ready, 2'b01);
        tick();
        req_valid = '0;
        wait_rsp(n);
        chk("t7_freq", rsp_freq, 32'h6E000000);
        chk("t7_starts", start_cnt - s0, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
